// File: rtl/wbu_csr_pkg.sv
// wbu_csr_pkg: shared CSR addresses, op encodings, cause codes and mstatus fields
package wbu_csr_pkg;
    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_ECALL = 2'b10,
        CSR_MRET  = 2'b11
    } csr_op_e;

    localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] MCAUSE_ECALL            = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
endpackage

// File: rtl/wbu_csr_if.sv
// wbu_csr_if: LSU-to-writeback instruction bus
interface wbu_csr_if;
    import wbu_csr_pkg::*;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        jump;
    logic [31:0] result;
    logic [4:0]  reg_rd;
    logic        reg_wen;
    csr_op_e     csr_t;
    logic [11:0] csr;
    logic [31:0] csr_wdata;
    logic        exception;
    logic [3:0]  mcause;
    modport master (
        output valid, pc, dnpc, jump, result, reg_rd, reg_wen, csr_t, csr, csr_wdata, exception, mcause,
        input  ready
    );
    modport slave (
        input  valid, pc, dnpc, jump, result, reg_rd, reg_wen, csr_t, csr, csr_wdata, exception, mcause,
        output ready
    );
endinterface

// File: rtl/wbu_csr_csr_file.sv
// wbu_csr_csr_file: machine-mode CSRs, 64-bit counters and combinational read mux
module wbu_csr_csr_file
    import wbu_csr_pkg::*;
#(
    parameter logic [31:0] MVENDORID   = 32'h7973_7978,
    parameter logic [31:0] MARCHID     = 32'd24110006,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        write_en,
    input  logic [11:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        trap,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    input  logic        retire,
    input  logic [11:0] raddr,
    output logic [31:0] rdata,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);
    logic [31:0] mstatus;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mstatus  <= MSTATUS_RESET;
            mtvec    <= MTVEC_RESET;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (retire)
                minstret <= minstret + 64'd1;
            if (trap) begin
                mepc                  <= trap_pc;
                mcause                <= trap_cause;
                mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
                mstatus[MSTATUS_MIE]  <= 1'b0;
            end else if (mret) begin
                mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
                mstatus[MSTATUS_MPIE] <= 1'b1;
            end else if (write_en) begin
                // counters and ID registers are read-only here
                if (write_addr == CSR_MSTATUS) mstatus <= write_data;
                if (write_addr == CSR_MTVEC)   mtvec   <= write_data;
                if (write_addr == CSR_MEPC)    mepc    <= write_data;
                if (write_addr == CSR_MCAUSE)  mcause  <= write_data;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CSR_MSTATUS:   rdata = mstatus;
            CSR_MTVEC:     rdata = mtvec;
            CSR_MEPC:      rdata = mepc;
            CSR_MCAUSE:    rdata = mcause;
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MVENDORID: rdata = MVENDORID;
            CSR_MARCHID:   rdata = MARCHID;
            default:       rdata = '0;
        endcase
    end
endmodule

// File: rtl/wbu_csr.sv
// wbu_csr: writeback stage committing instructions, owning the CSR file and issuing flush/redirect
module wbu_csr
    import wbu_csr_pkg::*;
#(
    parameter logic [31:0] MVENDORID   = 32'h7973_7978,
    parameter logic [31:0] MARCHID     = 32'd24110006,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    wbu_csr_if.slave    bus,
    input  logic [11:0] i_csr_raddr,
    output logic [31:0] o_csr_rdata,
    output logic        o_rf_wen,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic        o_commit,
    output logic [31:0] o_commit_pc
);
    logic        commit;
    logic        trap;
    logic        take_mret;
    logic        take_jump;
    logic        csr_wen;
    logic        retire;
    logic [31:0] trap_cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign bus.ready = 1'b1;
    // anything arriving in the flush cycle is younger than the redirect
    assign commit     = bus.valid & ~o_flush & ~i_reset;
    assign trap       = commit & (bus.exception | (bus.csr_t == CSR_ECALL));
    assign take_mret  = commit & ~bus.exception & (bus.csr_t == CSR_MRET);
    assign take_jump  = commit & ~bus.exception & bus.jump & ((bus.csr_t == CSR_NONE) | (bus.csr_t == CSR_WRITE));
    assign csr_wen    = commit & ~bus.exception & (bus.csr_t == CSR_WRITE);
    assign retire     = commit & ~trap;
    assign trap_cause = bus.exception ? {28'b0, bus.mcause} : {28'b0, MCAUSE_ECALL};
    assign o_rf_wen   = commit & bus.reg_wen & (bus.reg_rd != 5'd0) & ~bus.exception & (bus.csr_t != CSR_ECALL);
    assign o_rf_waddr = bus.reg_rd;
    assign o_rf_wdata = bus.result;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_flush       <= 1'b0;
            o_redirect_pc <= '0;
            o_commit      <= 1'b0;
            o_commit_pc   <= '0;
        end else begin
            o_flush  <= trap | take_mret | take_jump;
            o_commit <= commit & ~bus.exception;
            if (trap | take_mret | take_jump)
                o_redirect_pc <= trap ? mtvec : take_mret ? mepc : bus.dnpc;
            if (commit & ~bus.exception)
                o_commit_pc <= bus.pc;
        end
    end

    wbu_csr_csr_file #(
        .MVENDORID   (MVENDORID),
        .MARCHID     (MARCHID),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr_file (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .write_en   (csr_wen),
        .write_addr (bus.csr),
        .write_data (bus.csr_wdata),
        .trap       (trap),
        .trap_pc    (bus.pc),
        .trap_cause (trap_cause),
        .mret       (take_mret),
        .retire     (retire),
        .raddr      (i_csr_raddr),
        .rdata      (o_csr_rdata),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );
endmodule

// File: tb/tb_wbu_csr.sv
// tb_wbu_csr: directed plus randomized checks against an architectural reference model
module tb_wbu_csr;
    import wbu_csr_pkg::*;

    logic        clk;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        commit;
    logic [31:0] commit_pc;
    int          checks = 0;
    int          errors = 0;

    wbu_csr_if bus();

    wbu_csr dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .bus           (bus.slave),
        .i_csr_raddr   (csr_raddr),
        .o_csr_rdata   (csr_rdata),
        .o_rf_wen      (rf_wen),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata),
        .o_flush       (flush),
        .o_redirect_pc (redirect_pc),
        .o_commit      (commit),
        .o_commit_pc   (commit_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // architectural state of the reference model
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_redir, m_cpc;
    logic [63:0] m_cyc, m_inst;
    logic        m_flush, m_commit, init = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_inst[31:0];
            12'hB82: return m_inst[63:32];
            12'hF11: return 32'h7973_7978;
            12'hF12: return 32'd24110006;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic exc, input logic [3:0] mc, input logic [4:0] rd,
                         input logic wen, input logic [31:0] res, input logic jmp, input logic [31:0] dn,
                         input logic [11:0] ra);
        bus.valid = v; bus.pc = pc; bus.csr_t = csr_op_e'(op); bus.csr = a; bus.csr_wdata = wd;
        bus.exception = exc; bus.mcause = mc; bus.reg_rd = rd; bus.reg_wen = wen; bus.result = res;
        bus.jump = jmp; bus.dnpc = dn; csr_raddr = ra;
    endtask

    task automatic idle(input logic [11:0] ra);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra);
    endtask

    // one clock: check combinational outputs, advance model, check registered outputs
    task automatic step();
        logic c, exc, ec, mr, jp, wen_exp;
        logic [31:0] ms;
        @(negedge clk);
        c   = bus.valid && !m_flush && !rst;
        exc = c && bus.exception;
        ec  = c && !bus.exception && bus.csr_t == CSR_ECALL;
        mr  = c && !bus.exception && bus.csr_t == CSR_MRET;
        jp  = c && !bus.exception && bus.jump && (bus.csr_t == CSR_NONE || bus.csr_t == CSR_WRITE);
        wen_exp = c && bus.reg_wen && bus.reg_rd != 0 && !exc && !ec;
        if (init) begin
            chk("rf_wen", {31'b0, rf_wen}, {31'b0, wen_exp});
            if (wen_exp) begin
                chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, bus.reg_rd});
                chk("rf_wdata", rf_wdata, bus.result);
            end
            chk("csr_rdata", csr_rdata, mread(csr_raddr));
        end
        if (rst) begin
            m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_inst = 0;
            m_flush = 0; m_redir = 0; m_commit = 0; m_cpc = 0; init = 1'b1;
        end else begin
            m_cyc++;
            m_flush = exc || ec || mr || jp;
            if (exc || ec) m_redir = m_mtvec;
            else if (mr) m_redir = m_mepc;
            else if (jp) m_redir = bus.dnpc;
            m_commit = c && !bus.exception;
            if (m_commit) m_cpc = bus.pc;
            if (c && !exc && !ec) m_inst++;
            ms = m_mstatus;
            if (exc || ec) begin
                m_mepc = bus.pc;
                m_mcause = ec ? 32'd11 : {28'b0, bus.mcause};
                m_mstatus[7] = ms[3];
                m_mstatus[3] = 1'b0;
            end else if (mr) begin
                m_mstatus[3] = ms[7];
                m_mstatus[7] = 1'b1;
            end else if (c && bus.csr_t == CSR_WRITE) begin
                if (bus.csr == 12'h300) m_mstatus = bus.csr_wdata;
                if (bus.csr == 12'h305) m_mtvec = bus.csr_wdata;
                if (bus.csr == 12'h341) m_mepc = bus.csr_wdata;
                if (bus.csr == 12'h342) m_mcause = bus.csr_wdata;
            end
        end
        @(posedge clk);
        #1;
        if (init) begin
            chk("flush", {31'b0, flush}, {31'b0, m_flush});
            chk("commit", {31'b0, commit}, {31'b0, m_commit});
            if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
            if (m_commit) chk("commit_pc", commit_pc, m_cpc);
        end
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    logic [11:0] addrs [11] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h123};

    initial begin
        rst = 1'b1;
        idle(12'h300);
        step(); step();
        rst = 1'b0;
        peek("reset_mstatus", 12'h300, 32'h1800);
        drive(1, 32'h8000_0000, 0, 0, 0, 0, 0, 5, 1, 32'h1234, 0, 0, 12'hB02); step();
        peek("minstret_one", 12'hB02, 32'd1);
        drive(1, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 1, 32'h5555, 0, 0, 12'hB02); step();
        peek("minstret_rd0", 12'hB02, 32'd2);
        drive(1, 32'h8000_0008, 1, 12'h305, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 12'h305); step();
        peek("mtvec_written", 12'h305, 32'h8000_0100);
        drive(1, 32'h8000_000C, 1, 12'h300, 32'h1808, 0, 0, 0, 0, 0, 0, 0, 12'h300); step();
        drive(1, 32'h8000_0010, 0, 0, 0, 1, 4, 7, 1, 32'hDEAD, 0, 0, 12'h341); step();
        chk("trap_redirect", redirect_pc, 32'h8000_0100);
        peek("trap_mepc", 12'h341, 32'h8000_0010);
        peek("trap_mcause", 12'h342, 32'd4);
        peek("trap_mstatus", 12'h300, 32'h1880);
        drive(1, 32'h8000_0014, 1, 12'h305, 32'h1234, 0, 0, 9, 1, 32'hBEEF, 0, 0, 12'h305); step();
        peek("shadow_mtvec", 12'h305, 32'h8000_0100);
        drive(1, 32'h8000_0100, 0, 0, 0, 0, 0, 3, 1, 32'h77, 0, 0, 12'h342); step();
        drive(1, 32'h8000_0104, 1, 12'h341, 32'h8000_0014, 0, 0, 0, 0, 0, 0, 0, 12'h341); step();
        drive(1, 32'h8000_0108, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h300); step();
        chk("mret_redirect", redirect_pc, 32'h8000_0014);
        peek("mret_mstatus", 12'h300, 32'h1888);
        idle(12'h300); step();
        drive(1, 32'h8000_0014, 1, 12'hF11, 32'h0, 0, 0, 0, 0, 0, 0, 0, 12'hF11); step();
        drive(1, 32'h8000_0018, 1, 12'hB00, 32'h0, 0, 0, 0, 0, 0, 0, 0, 12'hB00); step();
        peek("mvendorid_ro", 12'hF11, 32'h7973_7978);
        drive(1, 32'h8000_001C, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1, 32'h8000_0400, 12'hB00); step();
        chk("jump_redirect", redirect_pc, 32'h8000_0400);
        drive(1, 32'h8000_0020, 2, 0, 0, 0, 0, 1, 1, 32'h20, 0, 0, 12'h342); step();
        idle(12'h342); step();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 10)],
                  $urandom, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0, $urandom,
                  addrs[$urandom_range(0, 10)]);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wbu_csr.md
Name: wbu_csr

Overview:
- Final pipeline stage, directly downstream of the load/store unit.
- Consumes each completed instruction (result, rd, CSR op, exception, jump) and commits it: drives the register-file write port and owns the machine-mode CSR file.
- Generates the single pipeline flush/redirect for traps, mret and jumps.
- Provides a combinational CSR read port to the execute stage, and a registered commit strobe for simulation/difftest.

Parameters:
- MVENDORID, 32'h7973_7978, value returned for CSR 0xF11.
- MARCHID, 32'd24110006, value returned for CSR 0xF12.
- MTVEC_RESET, 32'h0, reset value of mtvec.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  LSU output instruction valid; one-cycle pulse per instruction.
- o_ready  out  1  constant 1; this stage never back-pressures.
- i_pc  in  32  PC of the committing instruction.
- i_dnpc  in  32  jump target, meaningful when i_jump=1.
- i_jump  in  1  instruction redirects fetch to i_dnpc.
- i_result  in  32  rd write data (load data, ALU result, or old CSR value).
- i_reg_rd  in  5  destination register.
- i_reg_wen  in  1  rd write request.
- i_csr_t  in  2  CSR op: 00 none, 01 CSR write, 10 ecall, 11 mret.
- i_csr  in  12  CSR address for a CSR write.
- i_csr_wdata  in  32  new CSR value, already computed by EXU for rw/rs/rc.
- i_exception  in  1  upstream exception.
- i_mcause  in  4  exception code.
- i_csr_raddr  in  12  EXU CSR read address.
- o_csr_rdata  out  32  combinational read data.
- o_rf_wen  out  1  register-file write enable.
- o_rf_waddr  out  5  register-file write address.
- o_rf_wdata  out  32  register-file write data.
- o_flush  out  1  registered flush pulse to all upstream stages.
- o_redirect_pc  out  32  fetch target, valid while o_flush=1.
- o_commit  out  1  registered retire strobe.
- o_commit_pc  out  32  PC of the retired instruction.

Behaviour:
- Commit cycle: commit = i_valid & !o_flush. While o_flush is high the incoming instruction is younger than the redirect and is dropped with no side effects.
- Priority within a commit: i_exception > ecall > mret > i_jump > normal.
- Register-file write (combinational, written by the regfile at the edge):
  - o_rf_wen = commit & i_reg_wen & (i_reg_rd != 0) & !i_exception & (i_csr_t != 10).
  - o_rf_waddr = i_reg_rd; o_rf_wdata = i_result.
- Exception or ecall:
  - mepc <= i_pc.
  - mcause <= {28'b0, i_mcause}, or 32'd11 for ecall.
  - mstatus.MPIE <= MIE; MIE <= 0.
  - o_flush <= 1; o_redirect_pc <= mtvec.
  - No CSR write is performed.
- mret: MIE <= MPIE, MPIE <= 1, o_flush <= 1, o_redirect_pc <= mepc.
- Jump: o_flush <= 1, o_redirect_pc <= i_dnpc.
- CSR write (csr_t=01, no exception): writable registers are mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Writes to counters, ID registers and unknown addresses are ignored.
- o_flush: high for exactly one cycle after the commit edge, then 0. Back-to-back flushes are impossible because the next commit is suppressed.
- Counters:
  - mcycle is 64-bit and increments every non-reset cycle.
  - minstret is 64-bit and increments on commit without exception or ecall.
  - Reads: 0xB00/0xB80 return mcycle low/high; 0xB02/0xB82 return minstret low/high.
  - Both wrap at 2^64 silently.
- Read port:
  - Unknown address returns 0; 0xF11/0xF12 return the parameters.
  - Returns the architectural (register) value; a write committing in the same cycle is visible from the next cycle (no bypass).
- o_commit and o_commit_pc are registered from commit & !i_exception.
- Reset values:
  - o_flush = 0, o_commit = 0, o_redirect_pc = 0, o_commit_pc = 0.
  - mstatus = 32'h1800 (MPP = M), mtvec = MTVEC_RESET.
  - mepc = 0, mcause = 0, mcycle = 0, minstret = 0.
  - o_rf_wen is 0 whenever i_valid is 0.
- Reset mid-operation: a pending o_flush is cleared, and a commit in the reset cycle is discarded.

Decomposition:
- Shared package/header holds:
  - CSR address constants (CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE(H), CSR_MINSTRET(H), CSR_MVENDORID, CSR_MARCHID).
  - csr_t encodings (CSR_NONE, CSR_WRITE, CSR_ECALL, CSR_MRET).
  - mcause codes (4 load misaligned, 6 store misaligned, 11 ecall).
  - mstatus bit indices (MIE=3, MPIE=7).
- One sub-module, csr_file: CSR registers, counters, read mux, and trap/mret update ports. The wbu_csr top handles commit qualification, priority, the regfile port and flush/redirect.

Test Plan:
- Normal writeback: i_valid, rd=5, result=0x1234, reg_wen=1 -> o_rf_wen=1, waddr=5, wdata=0x1234 the same cycle; o_commit=1 with o_commit_pc=pc the next cycle; minstret=1.
- rd=0 with reg_wen=1 -> o_rf_wen=0, but still retires (minstret increments).
- Exception: mtvec=0x8000_0100, pc=0x8000_0010, i_exception=1, mcause=4, MIE=1 ->
  - next cycle: o_flush=1, redirect=0x8000_0100, mepc=0x8000_0010, mcause=4, MIE=0, MPIE=1, no rf write.
  - cycle after: o_flush=0.
- Flush shadow: a valid instruction presented in the o_flush cycle -> no rf write, no CSR change, no commit; the next valid instruction commits normally.
- mret after a trap: mepc=0x8000_0014 -> o_flush=1, redirect=0x8000_0014, MIE=1, MPIE=1.
- CSR write/read: csr_t=01, addr 0x305, wdata 0x8000_0200; read 0x305 in the same cycle -> old value; next cycle -> 0x8000_0200.
- Write attempts to 0xF11 and 0xB00 are ignored: 0xF11 still reads 0x79737978.
